cpu_clock_ctrl: RTL and testbench

Parametrised CPU clock-enable controller replacing the fixed 1 Hz divider in the top level. Generates a single-cycle `cpu_ce` strobe on the system clock, never a derived clock. Provides run/halt/single-step control from two raw push-buttons, four selectable tick rates, a CPU halt request input and a status blink output. Sits between the board buttons/LEDs and the CPU's clock-enable input.

---
 rtl/cpu_clock_pkg.sv | 15 +
 rtl/button_debounce.sv | 47 ++++
 rtl/cpu_clock_ctrl.sv | 115 +++++++++++
 tb/tb_cpu_clock_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clock_pkg.sv
// Shared types for the CPU clock-enable controller: FSM states and div_sel encodings.
package cpu_clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] DIV_SEL_0 = 2'd0;
    localparam logic [1:0] DIV_SEL_1 = 2'd1;
    localparam logic [1:0] DIV_SEL_2 = 2'd2;
    localparam logic [1:0] DIV_SEL_3 = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Raw active-low button -> synchronised, debounced level and a one-cycle press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] stable_cnt;
    logic             sync_pressed;

    assign sync_pressed = ~sync_q[1];

    // Any cycle where the synchronised level agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b11;
            level      <= 1'b0;
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_n};
            level_q <= level;
            if (sync_pressed != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync_pressed;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: run/halt/single-step FSM, selectable tick divider,
// blink and pulse counter. Produces a strobe on clk, never a derived clock.
module cpu_clock_ctrl
    import cpu_clock_pkg::*;
#(
    parameter int DIV_WIDTH       = 24,
    parameter int DIV0            = 12000000,
    parameter int DIV1            = 1200000,
    parameter int DIV2            = 12000,
    parameter int DIV3            = 1,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_mode_n,
    input  logic        btn_step_n,
    input  logic [1:0]  div_sel,
    input  logic        halt_req,
    output logic        cpu_ce,
    output logic        running,
    output logic        blink,
    output logic [15:0] tick_count
);

    localparam logic [DIV_WIDTH-1:0] LIM0 = DIV_WIDTH'(DIV0 - 1);
    localparam logic [DIV_WIDTH-1:0] LIM1 = DIV_WIDTH'(DIV1 - 1);
    localparam logic [DIV_WIDTH-1:0] LIM2 = DIV_WIDTH'(DIV2 - 1);
    localparam logic [DIV_WIDTH-1:0] LIM3 = DIV_WIDTH'(DIV3 - 1);

    state_t               state;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_limit;
    logic                 tick;
    logic                 mode_press;
    logic                 step_press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_mode_n),
        .press   (mode_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_step_n),
        .press   (step_press)
    );

    always_comb begin
        div_limit = LIM0;
        case (div_sel)
            DIV_SEL_0: div_limit = LIM0;
            DIV_SEL_1: div_limit = LIM1;
            DIV_SEL_2: div_limit = LIM2;
            DIV_SEL_3: div_limit = LIM3;
            default:   div_limit = LIM0;
        endcase
    end

    // >= so that switching to a faster rate mid-count fires at once instead of wrapping.
    assign tick = (div_cnt >= div_limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            div_cnt    <= '0;
            cpu_ce     <= 1'b0;
            running    <= 1'b1;
            blink      <= 1'b0;
            tick_count <= '0;
        end else begin
            cpu_ce <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (halt_req || mode_press) begin
                        state   <= ST_HALT;
                        running <= 1'b0;
                        div_cnt <= '0;
                    end else if (tick) begin
                        div_cnt    <= '0;
                        cpu_ce     <= 1'b1;
                        blink      <= ~blink;
                        tick_count <= tick_count + 16'd1;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_HALT: begin
                    div_cnt <= '0;
                    if (mode_press && !halt_req) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end else if (step_press && !mode_press) begin
                        state      <= ST_STEP;
                        cpu_ce     <= 1'b1;
                        blink      <= ~blink;
                        tick_count <= tick_count + 16'd1;
                    end
                end
                ST_STEP: begin
                    div_cnt <= '0;
                    state   <= ST_HALT;
                end
                default: begin
                    div_cnt <= '0;
                    state   <= ST_HALT;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed, self-checking bench for cpu_clock_ctrl with small divider/debounce values.
module tb_cpu_clock_ctrl;

    logic        clk;
    logic        reset_n;
    logic        btn_mode_n;
    logic        btn_step_n;
    logic [1:0]  div_sel;
    logic        halt_req;
    logic        cpu_ce;
    logic        running;
    logic        blink;
    logic [15:0] tick_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  div_sel;
        logic        halt_req;
        int          cycles;
        int          exp_pulses;
        logic [15:0] exp_ticks;
        logic        exp_blink;
        logic        exp_running;
    } vec_t;

    vec_t vecs[6];

    cpu_clock_ctrl #(
        .DIV0            (4),
        .DIV1            (2),
        .DIV3            (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_mode_n (btn_mode_n),
        .btn_step_n (btn_step_n),
        .div_sel    (div_sel),
        .halt_req   (halt_req),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .blink      (blink),
        .tick_count (tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        div_sel  = v.div_sel;
        halt_req = v.halt_req;
    endtask

    task automatic doReset(input logic [1:0] ds, input logic hr);
        btn_mode_n = 1'b1;
        btn_step_n = 1'b1;
        div_sel    = ds;
        halt_req   = hr;
        reset_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic firstPulse(input int limit, output int at);
        at = 0;
        for (int k = 1; k <= limit; k++) begin
            stepCycle();
            if (cpu_ce === 1'b1) begin
                at = k;
                break;
            end
        end
    endtask

    task automatic enterHalt();
        halt_req = 1'b1;
        stepCycle();
        halt_req = 1'b0;
        repeat (2) stepCycle();
    endtask

    initial begin
        int pulses;
        int at;
        int run_at;
        int high_cnt;
        logic [15:0] tc0;
        logic [4:0] pat;

        vecs[0] = '{2'd0, 1'b0, 32, 8, 16'd8, 1'b0, 1'b1};
        vecs[1] = '{2'd1, 1'b0, 10, 5, 16'd5, 1'b1, 1'b1};
        vecs[2] = '{2'd3, 1'b0,  7, 7, 16'd7, 1'b1, 1'b1};
        vecs[3] = '{2'd0, 1'b0,  3, 0, 16'd0, 1'b0, 1'b1};
        vecs[4] = '{2'd3, 1'b1,  6, 0, 16'd0, 1'b0, 1'b0};
        vecs[5] = '{2'd1, 1'b1,  5, 0, 16'd0, 1'b0, 1'b0};

        btn_mode_n = 1'b1;
        btn_step_n = 1'b1;
        div_sel    = 2'd0;
        halt_req   = 1'b0;
        reset_n    = 1'b0;
        #12;
        checkOutput("reset_cpu_ce", cpu_ce, 0);
        checkOutput("reset_running", running, 1);
        checkOutput("reset_blink", blink, 0);
        checkOutput("reset_tick_count", tick_count, 0);

        // Table: each vector starts from reset and runs a fixed number of cycles.
        for (int i = 0; i < 6; i++) begin
            doReset(vecs[i].div_sel, vecs[i].halt_req);
            applyStimulus(vecs[i]);
            pulses = 0;
            high_cnt = 0;
            for (int k = 0; k < vecs[i].cycles; k++) begin
                stepCycle();
                if (cpu_ce === 1'b1) pulses++;
                if (running !== vecs[i].exp_running) high_cnt++;
            end
            checkOutput($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            checkOutput($sformatf("vec%0d_tick_count", i), tick_count, vecs[i].exp_ticks);
            checkOutput($sformatf("vec%0d_blink", i), blink, vecs[i].exp_blink);
            checkOutput($sformatf("vec%0d_running_steady", i), high_cnt, 0);
        end

        // Mode press in RUN halts after sync + debounce + 1 cycles.
        doReset(2'd0, 1'b0);
        repeat (2) stepCycle();
        btn_mode_n = 1'b0;
        at = 0;
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            stepCycle();
            if (k == 10) btn_mode_n = 1'b1;
            if (running === 1'b0 && at == 0) at = k;
            if (at != 0 && cpu_ce === 1'b1) pulses++;
        end
        checkOutput("mode_halt_latency", at, 7);
        checkOutput("halt_no_pulses", pulses, 0);

        btn_mode_n = 1'b0;
        run_at = 0;
        for (int k = 1; k <= 12 && run_at == 0; k++) begin
            stepCycle();
            if (k == 10) btn_mode_n = 1'b1;
            if (running === 1'b1) run_at = k;
        end
        checkOutput("mode_run_latency", run_at, 7);
        firstPulse(10, at);
        checkOutput("resume_first_tick", at, 4);
        btn_mode_n = 1'b1;
        repeat (10) stepCycle();

        // Step button glitching then held while halted.
        doReset(2'd0, 1'b0);
        enterHalt();
        tc0 = tick_count;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            btn_step_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            stepCycle();
            if (cpu_ce === 1'b1) pulses++;
        end
        checkOutput("step_glitch_pulses", pulses, 0);
        high_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            stepCycle();
            if (cpu_ce === 1'b1) high_cnt++;
        end
        btn_step_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (cpu_ce === 1'b1) high_cnt++;
        end
        checkOutput("step_pulses", high_cnt, 1);
        checkOutput("step_tick_count", tick_count, 16'(tc0 + 16'd1));
        checkOutput("step_back_to_halt", running, 0);

        // Full speed, then halt_req blocks resume.
        doReset(2'd3, 1'b0);
        high_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            if (cpu_ce === 1'b1) high_cnt++;
        end
        checkOutput("div3_every_cycle", high_cnt, 3);
        halt_req = 1'b1;
        stepCycle();
        checkOutput("halt_req_ce_low", cpu_ce, 0);
        checkOutput("halt_req_running", running, 0);
        btn_mode_n = 1'b0;
        high_cnt = 0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            stepCycle();
            if (k == 10) btn_mode_n = 1'b1;
            if (running !== 1'b0) high_cnt++;
            if (cpu_ce === 1'b1) pulses++;
        end
        checkOutput("halt_req_blocks_mode", high_cnt, 0);
        checkOutput("halt_req_no_pulses", pulses, 0);
        halt_req = 1'b0;
        repeat (3) stepCycle();
        btn_mode_n = 1'b0;
        run_at = 0;
        for (int k = 1; k <= 12 && run_at == 0; k++) begin
            stepCycle();
            if (running === 1'b1) run_at = k;
        end
        btn_mode_n = 1'b1;
        checkOutput("halt_req_dropped_resume", run_at, 7);
        repeat (10) stepCycle();

        // Mode and step presses coincident while halted: mode wins.
        doReset(2'd0, 1'b0);
        enterHalt();
        tc0 = tick_count;
        btn_mode_n = 1'b0;
        btn_step_n = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 7; k++) begin
            stepCycle();
            if (cpu_ce === 1'b1) pulses++;
        end
        checkOutput("coincident_running", running, 1);
        checkOutput("coincident_no_step", pulses, 0);
        firstPulse(10, at);
        checkOutput("coincident_first_tick", at, 4);
        checkOutput("coincident_tick_count", tick_count, 16'(tc0 + 16'd1));
        btn_mode_n = 1'b1;
        btn_step_n = 1'b1;
        repeat (10) stepCycle();

        // Lower the divide ratio with the counter at 3.
        doReset(2'd0, 1'b0);
        repeat (3) stepCycle();
        div_sel = 2'd1;
        pat = '0;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            pat = {pat[3:0], cpu_ce};
        end
        checkOutput("div_switch_pattern", pat, 5'b10101);

        // Asynchronous reset during a STEP pulse.
        doReset(2'd0, 1'b0);
        enterHalt();
        btn_step_n = 1'b0;
        firstPulse(15, at);
        checkOutput("step_pulse_seen", (at != 0), 1);
        reset_n = 1'b0;
        btn_step_n = 1'b1;
        #1;
        checkOutput("rst_step_cpu_ce", cpu_ce, 0);
        checkOutput("rst_step_tick_count", tick_count, 0);
        checkOutput("rst_step_blink", blink, 0);
        checkOutput("rst_step_running", running, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        firstPulse(10, at);
        checkOutput("rst_step_first_tick", at, 4);

        // Asynchronous reset mid-count.
        doReset(2'd0, 1'b0);
        repeat (6) stepCycle();
        checkOutput("midcount_pre_ticks", tick_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_tick_count", tick_count, 0);
        checkOutput("rst_mid_blink", blink, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        firstPulse(10, at);
        checkOutput("rst_mid_first_tick", at, 4);

        // Counter wrap at full speed.
        doReset(2'd3, 1'b0);
        repeat (65535) stepCycle();
        checkOutput("wrap_pre_count", tick_count, 16'hFFFF);
        checkOutput("wrap_pre_blink", blink, 1);
        stepCycle();
        checkOutput("wrap_count", tick_count, 0);
        checkOutput("wrap_blink", blink, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
